// File: rtl/cnt_sweep_ctrl.sv
// Sweep initiator/checker for the up/down threshold counter: runs a programmed
// number of alternating-direction sweeps and checks every counter step.
module cnt_sweep_ctrl #(
    parameter int unsigned CW        = 4,
    parameter int unsigned SW        = 8,
    parameter int unsigned EW        = 8,
    parameter int unsigned WDOG_CYC  = 64,
    parameter int unsigned PAUSE_CYC = 2
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          start,
    input  logic [SW-1:0] num_sweeps,
    input  logic [CW-1:0] thresh,
    input  logic          dir_init,
    input  logic          timeout,
    input  logic [CW-1:0] cntout,
    output logic          enable,
    output logic          dn_up,
    output logic [CW-1:0] cnt_th,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] sweep_cnt,
    output logic [EW-1:0] err_cnt,
    output logic          err_step,
    output logic          err_wdog
);

    localparam int unsigned WDW = $clog2(WDOG_CYC + 1);
    localparam int unsigned PW  = $clog2(PAUSE_CYC + 1);
    localparam logic [WDW-1:0] WDOG_LAST  = WDW'(WDOG_CYC - 1);
    localparam logic [PW-1:0]  PAUSE_LAST = PW'(PAUSE_CYC - 1);
    // RUN cycles used only to capture cntout before step checking starts
    localparam logic [1:0]     SYNC_CYC   = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t         state;
    logic [SW-1:0]  num_q;
    logic [CW-1:0]  th_q;
    logic           dir_q;
    logic [WDW-1:0] wdog;
    logic [PW-1:0]  pause_cnt;
    logic [1:0]     sync_cnt;
    logic [CW-1:0]  prev;

    logic [CW-1:0]  step_exp_c;
    logic           step_bad_c;
    logic           wdog_exp_c;

    // Expected next counter value, wrapping modulo 2^CW
    assign step_exp_c = dn_up ? CW'(prev + CW'(1)) : CW'(prev - CW'(1));
    assign step_bad_c = (sync_cnt == SYNC_CYC) && (cntout != step_exp_c);
    assign wdog_exp_c = (wdog == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            num_q     <= '0;
            th_q      <= '0;
            dir_q     <= 1'b0;
            wdog      <= '0;
            pause_cnt <= '0;
            sync_cnt  <= '0;
            prev      <= '0;
            enable    <= 1'b0;
            dn_up     <= 1'b0;
            cnt_th    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_cnt <= '0;
            err_cnt   <= '0;
            err_step  <= 1'b0;
            err_wdog  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_q     <= num_sweeps;
                        th_q      <= thresh;
                        dir_q     <= dir_init;
                        sweep_cnt <= '0;
                        err_cnt   <= '0;
                        err_step  <= 1'b0;
                        err_wdog  <= 1'b0;
                        busy      <= 1'b1;
                        if (num_sweeps != '0) begin
                            state <= ARM;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ARM: begin
                    cnt_th   <= th_q;
                    dn_up    <= dir_q;
                    enable   <= 1'b1;
                    wdog     <= '0;
                    sync_cnt <= '0;
                    state    <= RUN;
                end

                RUN: begin
                    // prev always follows cntout, which also re-syncs after a mismatch
                    prev <= cntout;
                    if (sync_cnt != SYNC_CYC) begin
                        sync_cnt <= sync_cnt + 2'd1;
                    end
                    if (step_bad_c) begin
                        err_step <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + EW'(1);
                        end
                    end
                    if (timeout || wdog_exp_c) begin
                        if (!timeout) begin
                            err_wdog <= 1'b1;
                        end
                        sweep_cnt <= sweep_cnt + SW'(1);
                        enable    <= 1'b0;
                        pause_cnt <= '0;
                        state     <= PAUSE;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end

                PAUSE: begin
                    if (pause_cnt == '0) begin
                        dn_up <= ~dn_up;
                    end
                    if (pause_cnt == PAUSE_LAST) begin
                        if (sweep_cnt == num_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            enable   <= 1'b1;
                            wdog     <= '0;
                            sync_cnt <= '0;
                            state    <= RUN;
                        end
                    end else begin
                        pause_cnt <= pause_cnt + PW'(1);
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    enable <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Randomized scoreboard bench for cnt_sweep_ctrl with a behavioural sweep
// counter and a run-level reference model.
module tb_cnt_sweep_ctrl;

    localparam int unsigned CW        = 4;
    localparam int unsigned SW        = 8;
    localparam int unsigned EW        = 8;
    localparam int unsigned WDOG_CYC  = 64;
    localparam int unsigned PAUSE_CYC = 2;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          start;
    logic [SW-1:0] num_sweeps;
    logic [CW-1:0] thresh;
    logic          dir_init;
    logic          timeout;
    logic [CW-1:0] cntout;
    logic          enable;
    logic          dn_up;
    logic [CW-1:0] cnt_th;
    logic          busy;
    logic          done;
    logic [SW-1:0] sweep_cnt;
    logic [EW-1:0] err_cnt;
    logic          err_step;
    logic          err_wdog;

    cnt_sweep_ctrl #(
        .CW(CW), .SW(SW), .EW(EW), .WDOG_CYC(WDOG_CYC), .PAUSE_CYC(PAUSE_CYC)
    ) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .num_sweeps(num_sweeps),
        .thresh(thresh), .dir_init(dir_init), .timeout(timeout), .cntout(cntout),
        .enable(enable), .dn_up(dn_up), .cnt_th(cnt_th), .busy(busy), .done(done),
        .sweep_cnt(sweep_cnt), .err_cnt(err_cnt), .err_step(err_step), .err_wdog(err_wdog)
    );

    always #5 clk = ~clk;

    typedef struct {
        int done_cyc;
        int sweeps;
        int errs;
        int estep;
        int ewdog;
    } run_t;

    typedef struct {
        logic          dir;
        logic [CW-1:0] th;
    } sweep_t;

    run_t   exp_q[$];
    sweep_t dn_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int done_seen  = 0;
    int en_high    = 0;
    logic en_q     = 1'b0;

    // Counter stand-in: len = RUN cycle that raises timeout (0 = never);
    // inj_mode 1 skips one value in the first sweep, 2 skips two per sweep.
    int         len      = 0;
    int         inj_mode = 0;
    int         run_cyc  = 0;
    logic [7:0] steps    = 8'd0;
    logic       inj_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!enable) begin
            steps   <= 8'd0;
            run_cyc <= 0;
        end else begin
            run_cyc <= run_cyc + 1;
            if ((inj_mode == 2 && (steps == 8'd5 || steps == 8'd9)) ||
                (inj_mode == 1 && !inj_done && steps == 8'd5)) begin
                steps    <= steps + 8'd2;
                inj_done <= 1'b1;
            end else begin
                steps <= steps + 8'd1;
            end
        end
        if (!busy) inj_done <= 1'b0;
    end

    assign cntout  = dn_up ? steps[CW-1:0] : CW'(cnt_th - steps[CW-1:0]);
    assign timeout = enable && (len != 0) && (run_cyc == len - 1);

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: per-sweep direction/threshold and per-run results on done
    always @(negedge clk) begin
        if (n_reset === 1'b1) begin
            if (enable && !en_q) begin
                if (dn_q.size() == 0) begin
                    check("unexpected_sweep", 1, 0);
                end else begin
                    sweep_t s;
                    s = dn_q.pop_front();
                    check("sweep_dn_up", int'(dn_up), int'(s.dir));
                    check("sweep_cnt_th", int'(cnt_th), int'(s.th));
                end
            end
            if (enable) en_high++;
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    run_t r;
                    r = exp_q.pop_front();
                    check("done_cycle", cyc, r.done_cyc);
                    check("sweep_cnt", int'(sweep_cnt), r.sweeps);
                    check("err_cnt", int'(err_cnt), r.errs);
                    check("err_step", int'(err_step), r.estep);
                    check("err_wdog", int'(err_wdog), r.ewdog);
                    check("busy_at_done", int'(busy), 1);
                end
            end
        end
        en_q = enable;
    end

    // Reference model of one run, pushed when start is driven
    task automatic issue(input int n, input int th, input bit dir, input int ln, input int mode);
        run_t r;
        sweep_t s;
        int eff_l;
        @(negedge clk);
        len        = ln;
        inj_mode   = mode;
        num_sweeps = SW'(n);
        thresh     = CW'(th);
        dir_init   = dir;
        start      = 1'b1;
        eff_l      = (ln == 0 || ln > int'(WDOG_CYC)) ? int'(WDOG_CYC) : ln;
        r.done_cyc = cyc + 1 + ((n == 0) ? 0 : 1 + n * (eff_l + int'(PAUSE_CYC)));
        r.sweeps   = n;
        if (n == 0)         r.errs = 0;
        else if (mode == 1) r.errs = 1;
        else if (mode == 2) r.errs = (2 * n > 255) ? 255 : 2 * n;
        else                r.errs = 0;
        r.estep = (r.errs > 0) ? 1 : 0;
        r.ewdog = (n > 0 && (ln == 0 || ln > int'(WDOG_CYC))) ? 1 : 0;
        exp_q.push_back(r);
        for (int i = 0; i < n; i++) begin
            s.dir = dir ^ i[0];
            s.th  = CW'(th);
            dn_q.push_back(s);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int i;
        i = 0;
        while (done_seen < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_reached", done_seen, target);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_enable"}, int'(enable), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_dn_up"}, int'(dn_up), 0);
        check({tag, "_cnt_th"}, int'(cnt_th), 0);
        check({tag, "_sweep_cnt"}, int'(sweep_cnt), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_err_step"}, int'(err_step), 0);
        check({tag, "_err_wdog"}, int'(err_wdog), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int target;
        int en_before;
        int n, th, ln, mode, sel, eff;
        bit dir;

        n_reset    = 1'b0;
        start      = 1'b0;
        num_sweeps = '0;
        thresh     = '0;
        dir_init   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        n_reset = 1'b1;
        target  = 0;

        // Single up sweep 0..12
        issue(1, 12, 1'b1, 13, 0);
        target++; wait_done(target, 2000);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Three sweeps starting down
        issue(3, 9, 1'b0, 10, 0);
        target++; wait_done(target, 2000);

        // One skipped value in the first sweep
        issue(1, 12, 1'b1, 13, 1);
        target++; wait_done(target, 2000);

        // Watchdog: timeout never arrives
        issue(2, 5, 1'b1, 0, 0);
        target++; wait_done(target, 2000);

        // Timeout coincides with watchdog expiry
        issue(1, 7, 1'b0, int'(WDOG_CYC), 0);
        target++; wait_done(target, 2000);

        // Error counter saturation
        issue(130, 11, 1'b1, 11, 2);
        target++; wait_done(target, 5000);

        // start while busy must be ignored
        issue(2, 6, 1'b1, 8, 0);
        while (!enable) @(negedge clk);
        num_sweeps = SW'(9);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target++; wait_done(target, 2000);

        // num_sweeps == 0: done without any sweep
        en_before = en_high;
        issue(0, 3, 1'b1, 4, 0);
        target++; wait_done(target, 100);
        repeat (3) @(negedge clk);
        check("zero_run_enable_cycles", en_high, en_before);

        // Reset in the middle of a sweep
        issue(3, 10, 1'b1, 11, 0);
        while (!enable) @(negedge clk);
        repeat (4) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        check_zero("midrun_reset");
        exp_q.delete();
        dn_q.delete();
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized runs
        for (int k = 0; k < 15; k++) begin
            n   = $urandom_range(0, 5);
            th  = $urandom_range(0, 15);
            dir = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel == 0)      ln = 0;
            else if (sel == 1) ln = int'(WDOG_CYC);
            else if (sel == 2) ln = int'(WDOG_CYC) + 1;
            else               ln = $urandom_range(2, 20);
            eff = (ln == 0 || ln > int'(WDOG_CYC)) ? int'(WDOG_CYC) : ln;
            if (eff >= 10)     mode = $urandom_range(0, 2);
            else if (eff >= 7) mode = $urandom_range(0, 1);
            else               mode = 0;
            issue(n, th, dir, ln, mode);
            target++; wait_done(target, 3000);
        end

        repeat (5) @(negedge clk);
        check("leftover_runs", exp_q.size(), 0);
        check("leftover_sweeps", dn_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
